// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder block: FSM states,
// data/address widths and the data word returned for write responses.
package mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  // Wide enough to hold LATENCY-1 for the largest legal LATENCY of 15.
  localparam int unsigned CNT_W  = 4;

  localparam logic [DATA_W-1:0] NOP_DATA = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
interface mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: one access per enabled edge, write or read.
// Read data is registered and holds its value until the next enabled read.
module sp_ram #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset; contents must
  // survive a block reset, and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, performs the
// storage access LATENCY-1 edges later and holds the response until taken.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  access;
  logic                  ram_en;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  in_idle;

  // Upper address bits alias onto the lower ones by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:DEPTH_LOG2];

  assign in_idle = (state_q == IDLE);

  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    access  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[DEPTH_LOG2-1:0];
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // With LATENCY=1 the access shares the acceptance edge, so the operands
  // come straight from the bus rather than the not-yet-loaded registers.
  assign ram_en    = access && !rst;
  assign ram_we    = in_idle ? bus.req_we : we_q;
  assign ram_addr  = in_idle ? bus.req_addr[DEPTH_LOG2-1:0] : addr_q;
  assign ram_wdata = in_idle ? bus.req_wdata : wdata_q;

  sp_ram #(
    .ADDR_BITS (DEPTH_LOG2),
    .DATA_BITS (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we && ram_en),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Outputs are forced to their idle values for the whole time rst is high.
  assign bus.req_ready = in_idle && !rst;
  assign bus.busy      = !in_idle && !rst;
  assign bus.rsp_valid = (state_q == RESP) && !rst;
  assign bus.rsp_rdata = (bus.rsp_valid && !we_q) ? ram_rdata : NOP_DATA;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance driven from a vector
// table plus corner sequences, and a LATENCY=1 instance for back-to-back use.
module tb_mem_responder;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  localparam int NV      = 8;
  localparam int MAX_LAT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  mem_responder #(.LATENCY(4), .DEPTH_LOG2(10)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  mem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete transaction on the LATENCY=4 instance with rsp_ready high.
  // lat counts edges from acceptance to the edge where rsp_valid is sampled.
  task automatic txn_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       output int lat, output logic [15:0] rdata);
    ifa.req_valid = 1'b1;
    ifa.req_we    = we;
    ifa.req_addr  = addr;
    ifa.req_wdata = wdata;
    ifa.rsp_ready = 1'b1;
    check("txn_req_ready", 32'(ifa.req_ready), 32'd1);
    tick();
    ifa.req_valid = 1'b0;
    ifa.req_we    = ~we;
    ifa.req_addr  = ~addr;
    ifa.req_wdata = ~wdata;
    lat = 1;
    while (!ifa.rsp_valid && lat <= MAX_LAT) begin
      tick();
      lat++;
    end
    rdata = ifa.rsp_rdata;
    tick();
    check("txn_rsp_drop", 32'(ifa.rsp_valid), 32'd0);
  endtask

  vec_t        vec [NV];
  int          lat;
  logic [15:0] rdata;

  initial begin
    vec[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vec[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vec[2] = '{1'b1, 16'h0405, 16'h1234, 16'h0000};
    vec[3] = '{1'b0, 16'h0005, 16'h0000, 16'h1234};
    vec[4] = '{1'b1, 16'h0003, 16'hAAAA, 16'h0000};
    vec[5] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000};
    vec[6] = '{1'b0, 16'h03FF, 16'h0000, 16'h0001};
    vec[7] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};

    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifa.rsp_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    ifb.rsp_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_req_ready", 32'(ifa.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    check("rst_busy",      32'(ifa.busy),      32'd0);
    check("rst_rdata",     32'(ifa.rsp_rdata), 32'h0);
    check("rst_b_ready",   32'(ifb.req_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(ifa.req_ready), 32'd1);
    check("post_rst_busy",  32'(ifa.busy),      32'd0);

    // Vector table on the LATENCY=4 instance
    for (int i = 0; i < NV; i++) begin
      txn_a(vec[i].we, vec[i].addr, vec[i].wdata, lat, rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vec[i].exp_rdata));
    end

    // Response held by rsp_ready=0 for three cycles
    ifa.req_valid = 1'b1; ifa.req_we = 1'b0; ifa.req_addr = 16'h0010; ifa.rsp_ready = 1'b0;
    tick();
    ifa.req_valid = 1'b0;
    lat = 1;
    while (!ifa.rsp_valid && lat <= MAX_LAT) begin
      tick();
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d_valid", k), 32'(ifa.rsp_valid), 32'd1);
      check($sformatf("hold%0d_rdata", k), 32'(ifa.rsp_rdata), 32'hBEEF);
      check($sformatf("hold%0d_busy", k),  32'(ifa.busy),      32'd1);
      check($sformatf("hold%0d_ready", k), 32'(ifa.req_ready), 32'd0);
      tick();
    end
    check("hold_still_valid", 32'(ifa.rsp_valid), 32'd1);
    ifa.rsp_ready = 1'b1;
    tick();
    check("hold_release_valid", 32'(ifa.rsp_valid), 32'd0);
    check("hold_release_busy",  32'(ifa.busy),      32'd0);

    // Reset on the second WAIT cycle aborts a write
    ifa.req_valid = 1'b1; ifa.req_we = 1'b1; ifa.req_addr = 16'h0003; ifa.req_wdata = 16'h5555;
    tick();
    ifa.req_valid = 1'b0;
    tick();
    check("abort_busy_wait", 32'(ifa.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rst_ready", 32'(ifa.req_ready), 32'd0);
    check("abort_rst_valid", 32'(ifa.rsp_valid), 32'd0);
    check("abort_rst_busy",  32'(ifa.busy),      32'd0);
    check("abort_rst_rdata", 32'(ifa.rsp_rdata), 32'h0);
    tick();
    check("abort_rst2_busy", 32'(ifa.busy), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_after", 32'(ifa.req_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("abort_no_rsp%0d", k), 32'(ifa.rsp_valid), 32'd0);
    end
    txn_a(1'b0, 16'h0003, 16'h0000, lat, rdata);
    check("abort_read_rdata", 32'(rdata), 32'hAAAA);

    // req_valid during WAIT is ignored
    ifa.req_valid = 1'b1; ifa.req_we = 1'b0; ifa.req_addr = 16'h0010; ifa.rsp_ready = 1'b1;
    tick();
    ifa.req_we = 1'b1; ifa.req_addr = 16'h0003; ifa.req_wdata = 16'hDEAD;
    lat = 1;
    while (!ifa.rsp_valid && lat <= MAX_LAT) begin
      check($sformatf("ignore_ready_wait%0d", lat), 32'(ifa.req_ready), 32'd0);
      tick();
      lat++;
    end
    check("ignore_latency", 32'(lat), 32'd4);
    check("ignore_rdata",   32'(ifa.rsp_rdata), 32'hBEEF);
    ifa.req_valid = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("ignore_no_extra%0d", k), 32'(ifa.rsp_valid), 32'd0);
      tick();
    end
    txn_a(1'b0, 16'h0003, 16'h0000, lat, rdata);
    check("ignore_no_write", 32'(rdata), 32'hAAAA);

    // LATENCY=1: one write, then back-to-back reads with req_valid held high
    ifb.req_valid = 1'b1; ifb.req_we = 1'b1; ifb.req_addr = 16'h0005; ifb.req_wdata = 16'h0077;
    check("b_wr_ready", 32'(ifb.req_ready), 32'd1);
    tick();
    ifb.req_valid = 1'b0;
    check("b_wr_valid", 32'(ifb.rsp_valid), 32'd1);
    check("b_wr_rdata", 32'(ifb.rsp_rdata), 32'h0);
    tick();
    check("b_wr_drop", 32'(ifb.rsp_valid), 32'd0);
    ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_addr = 16'h0405;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b%0d_ready", k), 32'(ifb.req_ready), 32'((k % 2) == 0));
      check($sformatf("b2b%0d_valid", k), 32'(ifb.rsp_valid), 32'((k % 2) == 1));
      if ((k % 2) == 1) begin
        check($sformatf("b2b%0d_rdata", k), 32'(ifb.rsp_rdata), 32'h0077);
      end
      tick();
    end
    ifb.req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
